// File: rtl/apb_spi_fifo_regs.sv
// apb_spi_fifo_regs: zero-wait APB register block feeding an SPI engine through TX/RX FIFOs
module apb_spi_fifo_regs #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int NUM_SS     = 2
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [2:0]        PADDR,
  input  logic [15:0]       PWDATA,
  output logic [15:0]       PRDATA,
  output logic              PREADY,
  output logic              PSLVERR,
  input  logic              ss_in_n,
  input  logic              tip,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic [DATA_W-1:0] tx_data,
  input  logic              rx_valid,
  input  logic [DATA_W-1:0] rx_data,
  output logic              mstr,
  output logic              cpol,
  output logic              cpha,
  output logic              lsbfe,
  output logic              spiswai,
  output logic [2:0]        sppr,
  output logic [2:0]        spr,
  output logic [1:0]        spi_mode,
  output logic [NUM_SS-1:0] ss_n,
  output logic              spi_irq
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  typedef enum logic [1:0] {RUN = 2'b00, WAIT = 2'b01, STOP = 2'b10} mode_t;
  mode_t             r_mode;
  logic [7:0]        r_cr1, r_cr2, r_br;
  logic [NUM_SS-1:0] r_ssr;
  logic              r_modf, r_rxovf;
  logic [DATA_W-1:0] r_tx_mem [FIFO_DEPTH];
  logic [DATA_W-1:0] r_rx_mem [FIFO_DEPTH];
  logic [AW-1:0]     r_tx_wp, r_tx_rp, r_rx_wp, r_rx_rp;
  logic [CW-1:0]     r_tx_cnt, r_rx_cnt;
  logic w_acc, w_wr, w_rd, w_dr, w_rsv, w_lock;
  logic w_tx_full, w_tx_empty, w_rx_full, w_rx_empty;
  logic w_tx_push, w_tx_pop, w_rx_in, w_rx_push, w_rx_pop;
  logic w_modf_set, w_sr_wr, w_unused;
  logic [7:0] w_sr, w_cr1_nx;
  assign w_acc      = PSEL & PENABLE;
  assign w_wr       = w_acc & PWRITE;
  assign w_rd       = w_acc & ~PWRITE;
  assign w_dr       = PADDR == 3'd5;
  assign w_rsv      = PADDR[2] & PADDR[1];
  assign w_lock     = tip & (PADDR == 3'd0 | PADDR == 3'd2);
  assign w_sr_wr    = w_wr & PADDR == 3'd3;
  assign w_tx_full  = r_tx_cnt == CW'(FIFO_DEPTH);
  assign w_tx_empty = r_tx_cnt == '0;
  assign w_rx_full  = r_rx_cnt == CW'(FIFO_DEPTH);
  assign w_rx_empty = r_rx_cnt == '0;
  assign w_tx_push  = w_wr & w_dr & ~w_tx_full;
  assign w_tx_pop   = tx_valid & tx_ready;
  assign w_rx_in    = rx_valid & r_mode != STOP;
  assign w_rx_push  = w_rx_in & ~w_rx_full;
  assign w_rx_pop   = w_rd & w_dr & ~w_rx_empty;
  assign w_modf_set = r_cr1[4] & r_cr2[4] & ~r_cr1[1] & ~ss_in_n;
  assign w_cr1_nx   = (w_wr & PADDR == 3'd0 & ~tip) ? PWDATA[7:0] : r_cr1;
  assign w_sr       = {~w_rx_empty, 1'b0, ~w_tx_full, r_modf, r_rxovf, w_tx_empty, tip, 1'b0};
  assign w_unused   = ^PWDATA;
  assign PREADY     = w_acc;
  assign PSLVERR    = w_acc & (w_rsv | (w_wr & w_dr & w_tx_full) | (w_rd & w_dr & w_rx_empty) | (w_wr & w_lock));
  assign PRDATA     = !w_rd ? '0 :
                      PADDR == 3'd0 ? 16'(r_cr1) :
                      PADDR == 3'd1 ? 16'(r_cr2) :
                      PADDR == 3'd2 ? 16'(r_br) :
                      PADDR == 3'd3 ? 16'(w_sr) :
                      PADDR == 3'd4 ? 16'(r_ssr) :
                      (w_dr & ~w_rx_empty) ? 16'(r_rx_mem[r_rx_rp]) : '0;
  assign tx_valid   = ~w_tx_empty & r_mode == RUN;
  assign tx_data    = r_tx_mem[r_tx_rp];
  assign mstr       = r_cr1[4];
  assign cpol       = r_cr1[3];
  assign cpha       = r_cr1[2];
  assign lsbfe      = r_cr1[0];
  assign spiswai    = r_cr2[1];
  assign sppr       = r_br[6:4];
  assign spr        = r_br[2:0];
  assign spi_mode   = r_mode;
  assign ss_n       = (r_cr1[4] & r_cr1[1]) ? ~r_ssr : '1;
  assign spi_irq    = (r_cr1[7] & (~w_rx_empty | r_modf | r_rxovf)) | (r_cr1[5] & ~w_tx_full);
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_cr1    <= 8'h04;
      r_cr2    <= '0;
      r_br     <= '0;
      r_ssr    <= '0;
      r_modf   <= 1'b0;
      r_rxovf  <= 1'b0;
      r_tx_wp  <= '0;
      r_tx_rp  <= '0;
      r_tx_cnt <= '0;
      r_rx_wp  <= '0;
      r_rx_rp  <= '0;
      r_rx_cnt <= '0;
      r_mode   <= RUN;
    end else begin
      r_cr1   <= w_modf_set ? (w_cr1_nx & 8'hEF) : w_cr1_nx;
      if (w_wr & PADDR == 3'd1) r_cr2 <= PWDATA[7:0] & 8'h1B;
      if (w_wr & PADDR == 3'd2 & ~tip) r_br <= PWDATA[7:0] & 8'h77;
      if (w_wr & PADDR == 3'd4) r_ssr <= PWDATA[NUM_SS-1:0];
      r_modf  <= w_modf_set | (r_modf & ~(w_sr_wr & PWDATA[4]));
      r_rxovf <= (w_rx_in & w_rx_full) | (r_rxovf & ~(w_sr_wr & PWDATA[3]));
      if (w_tx_push) begin
        r_tx_mem[r_tx_wp] <= PWDATA[DATA_W-1:0];
        r_tx_wp           <= r_tx_wp + 1'b1;
      end
      if (w_tx_pop) r_tx_rp <= r_tx_rp + 1'b1;
      r_tx_cnt <= r_tx_cnt + CW'(w_tx_push) - CW'(w_tx_pop);
      if (w_rx_push) begin
        r_rx_mem[r_rx_wp] <= rx_data;
        r_rx_wp           <= r_rx_wp + 1'b1;
      end
      if (w_rx_pop) r_rx_rp <= r_rx_rp + 1'b1;
      r_rx_cnt <= r_rx_cnt + CW'(w_rx_push) - CW'(w_rx_pop);
      r_mode   <= r_mode == RUN  ? (r_cr1[6] ? RUN : WAIT) :
                  r_mode == WAIT ? (r_cr1[6] ? RUN : r_cr2[1] ? STOP : WAIT) :
                                   (r_cr1[6] ? RUN : ~r_cr2[1] ? WAIT : STOP);
    end
  end
endmodule
